// File: rtl/cfb_ctrl.sv
// cfb_ctrl: AES-128 CFB mode sequencer.
// Launches one forward-cipher operation per block on the feedback register,
// XORs the keystream with each input block and feeds ciphertext back.
module cfb_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_start,
  output logic [127:0]     core_din,
  output logic [127:0]     core_key,
  input  logic             core_done,
  input  logic [127:0]     core_dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_CORE = 3'd2,
    WAIT_IN   = 3'd3,
    OUT       = 3'd4
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  state_t         r_state;
  state_t         w_state_next;
  logic           r_done;
  logic           w_done_next;
  logic [127:0]   r_key;
  logic [127:0]   r_fb;
  logic [127:0]   r_ks;
  logic [127:0]   r_out;
  logic           r_mode;
  logic [LEN_W:0] r_rem;

  logic           w_load;
  logic           w_core_fire;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_last;
  logic [127:0]   w_xor;

  // Handshake qualifiers: each event only counts in the state that owns it.
  assign w_load      = (r_state == IDLE)      && start;
  assign w_core_fire = (r_state == WAIT_CORE) && core_done;
  assign w_in_fire   = (r_state == WAIT_IN)   && in_valid;
  assign w_out_fire  = (r_state == OUT)       && out_ready;
  assign w_last      = (r_rem == CNT_ONE);
  assign w_xor       = in_data ^ r_ks;

  // Outputs are pure decodes of the state and datapath registers.
  assign in_ready   = (r_state == WAIT_IN);
  assign out_valid  = (r_state == OUT);
  assign out_data   = r_out;
  assign core_start = (r_state == LAUNCH);
  assign core_din   = r_fb;
  assign core_key   = r_key;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  // State register and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic; done fires when the final block leaves OUT.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE:      if (start) w_state_next = LAUNCH;
      LAUNCH:    w_state_next = WAIT_CORE;
      WAIT_CORE: if (core_done) w_state_next = WAIT_IN;
      WAIT_IN:   if (in_valid) w_state_next = OUT;
      OUT: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = LAUNCH;
          end
        end
      end
      default:   w_state_next = IDLE;
    endcase
  end

  // Datapath: operands latched at start, keystream capture, feedback update,
  // and the block counter (len=0 means a full 2^LEN_W blocks).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_fb   <= '0;
      r_ks   <= '0;
      r_out  <= '0;
      r_mode <= 1'b0;
      r_rem  <= '0;
    end else begin
      if (w_load) begin
        r_key  <= key;
        r_fb   <= iv;
        r_mode <= mode;
        r_rem  <= (len == '0) ? CNT_FULL : {1'b0, len};
      end
      if (w_core_fire) begin
        r_ks <= core_dout;
      end
      if (w_in_fire) begin
        r_out <= w_xor;
        // Feedback is always the ciphertext: our output when encrypting,
        // the incoming block when decrypting.
        r_fb  <= r_mode ? in_data : w_xor;
      end
      if (w_out_fire) begin
        r_rem <= r_rem - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cfb_ctrl.sv
// tb_cfb_ctrl: randomized scoreboard bench for cfb_ctrl with a behavioural
// 10-cycle AES-128 core and a block-level CFB reference model.
module tb_cfb_ctrl;
  localparam int LEN_W = 2;

  logic             clk = 1'b0;
  logic             rst, start, mode;
  logic [127:0]     key, iv;
  logic [LEN_W-1:0] len;
  logic             in_valid, in_ready;
  logic [127:0]     in_data;
  logic             out_valid, out_ready;
  logic [127:0]     out_data;
  logic             core_start;
  logic [127:0]     core_din, core_key;
  logic             core_done;
  logic [127:0]     core_dout;
  logic             busy, done;

  always #5 clk = ~clk;

  cfb_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .iv(iv),
    .len(len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_din(core_din), .core_key(core_key),
    .core_done(core_done), .core_dout(core_dout), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- AES-128 forward cipher (reference) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0]  t, r;
    logic [15:0] d;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gm(t, t);
      r = gm(r, t);
    end
    d = {r, r};
    return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [127:0] rk, o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) n[r+4*c] = s[r + 4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gm(n[4*c],2) ^ gm(n[4*c+1],3) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gm(n[4*c+1],2) ^ gm(n[4*c+2],3) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gm(n[4*c+2],2) ^ gm(n[4*c+3],3);
          s[4*c+3] = gm(n[4*c],3) ^ n[4*c+1] ^ n[4*c+2] ^ gm(n[4*c+3],2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = n[4*c+r];
        end
      end
      rk = {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_out_q [$];
  logic [127:0] exp_din_q [$];
  logic [127:0] run_key;
  logic [127:0] blk_in  [4];
  logic [127:0] blk_exp [4];
  logic [127:0] din_exp [4];
  int           done_cnt    = 0;
  bit           force_stall = 1'b0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // CFB at block level: ks = E(K, fb); out = in ^ ks; fb = ciphertext.
  task automatic model(input logic [127:0] k, input logic [127:0] v, input bit m, input int n);
    logic [127:0] fb, o;
    fb = v;
    for (int i = 0; i < n; i++) begin
      din_exp[i] = fb;
      o = blk_in[i] ^ aes128(k, fb);
      blk_exp[i] = o;
      fb = m ? blk_in[i] : o;
    end
  endtask

  // Behavioural AES core: result appears 10 cycles after core_start.
  int           core_cnt = 0;
  logic [127:0] core_res;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_dout = core_res;
      end
    end
    if (core_start) begin
      if (exp_din_q.size() == 0) fail("core_start_unexpected");
      else check("core_din", core_din, exp_din_q.pop_front());
      check("core_key", core_key, run_key);
      core_res = aes128(core_key, core_din);
      core_cnt = 10;
    end
  end

  // Output-side monitor: drives out_ready (with stalls) and pops the scoreboard.
  int           stall = 0;
  bit           prev_stall = 1'b0;
  bit           prev_ov = 1'b0;
  logic [127:0] prev_data;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) stall = force_stall ? 5 : $urandom_range(0, 2);
    if (out_valid && stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if (done) begin
      done_cnt++;
      check("done_with_out_valid", 128'(out_valid), 128'd0);
    end
    if (prev_stall) begin
      check("stall_valid_held", 128'(out_valid), 128'd1);
      check("stall_data_stable", out_data, prev_data);
    end
    if (out_valid) begin
      check("out_in_ready_low", 128'(in_ready), 128'd0);
      check("out_core_start_low", 128'(core_start), 128'd0);
    end
    if (out_valid && out_ready) begin
      if (exp_out_q.size() == 0) fail("out_unexpected_block");
      else check("out_data", out_data, exp_out_q.pop_front());
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_ov    = out_valid;
  end

  task automatic flush();
    exp_out_q.delete();
    exp_din_q.delete();
  endtask

  // One message: blk_in/blk_exp/din_exp must be prepared. With abort set the
  // run is reset while block 1's keystream is being generated.
  task automatic run(input logic [127:0] k, input logic [127:0] v, input bit m,
                     input logic [LEN_W-1:0] l, input int n, input bit spurious, input bit abort);
    int d0, t;
    d0 = done_cnt;
    run_key = k;
    for (int i = 0; i < n; i++) exp_din_q.push_back(din_exp[i]);
    @(negedge clk);
    key = k; iv = v; mode = m; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = rnd128(); iv = rnd128(); mode = ~m; len = LEN_W'($urandom);
    for (int i = 0; i < n; i++) begin
      in_data  = blk_in[i];
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        fail("in_ready_timeout");
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush();
        return;
      end
      exp_out_q.push_back(blk_exp[i]);
      @(negedge clk);
      if (abort && i == 0) begin
        in_valid = 1'b0;
        t = 0;
        while ((exp_out_q.size() != 0 || !core_start) && t < 200) begin
          @(negedge clk);
          t++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush();
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd0);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        repeat (15) @(negedge clk);
        check("abort_busy_after_late_done", 128'(busy), 128'd0);
        check("abort_no_done", 128'(done_cnt - d0), 128'd0);
        return;
      end
      if (spurious && i == 0) begin
        start = 1'b1;
        key = rnd128(); iv = rnd128(); mode = ~m; len = LEN_W'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", 128'(done_cnt - d0), 128'd1);
    check("busy_after_done", 128'(busy), 128'd0);
    check("out_queue_drained", 128'(exp_out_q.size()), 128'd0);
    check("launch_queue_drained", 128'(exp_din_q.size()), 128'd0);
    flush();
  endtask

  localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C0 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] C1 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;

  task automatic known_enc(input bit abort);
    blk_in[0] = P0; blk_in[1] = P1;
    model(K, IV, 1'b0, 2);
    blk_exp[0] = C0; blk_exp[1] = C1;
    din_exp[1] = C0;
    run(K, IV, 1'b0, LEN_W'(2), 2, 1'b0, abort);
  endtask

  initial begin
    logic [127:0]     k, v;
    bit               m;
    logic [LEN_W-1:0] l;
    int               n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; iv = '0; len = '0;
    in_valid = 1'b0; in_data = '0; run_key = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_core_start", 128'(core_start), 128'd0);
    check("rst_core_din", core_din, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rst = 1'b0;

    // Known-answer encrypt with a 5-cycle output stall on each block.
    force_stall = 1'b1;
    known_enc(1'b0);
    force_stall = 1'b0;

    // Known-answer decrypt; second launch must use C0 as cipher input.
    blk_in[0] = C0; blk_in[1] = C1;
    model(K, IV, 1'b1, 2);
    blk_exp[0] = P0; blk_exp[1] = P1;
    din_exp[1] = C0;
    run(K, IV, 1'b1, LEN_W'(2), 2, 1'b0, 1'b0);

    // Reset during block 1 keystream generation, then a clean rerun.
    known_enc(1'b1);
    known_enc(1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; key = rnd128(); len = LEN_W'(1);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_beats_start_busy", 128'(busy), 128'd0);

    // len=0 -> 2^LEN_W blocks, with a start pulse ignored mid-run.
    k = rnd128(); v = rnd128();
    for (int i = 0; i < 4; i++) blk_in[i] = rnd128();
    model(k, v, 1'b0, 4);
    run(k, v, 1'b0, LEN_W'(0), 4, 1'b1, 1'b0);

    // Randomized messages.
    for (int r = 0; r < 20; r++) begin
      k = rnd128(); v = rnd128();
      m = 1'($urandom_range(0, 1));
      l = LEN_W'($urandom_range(0, 3));
      n = (l == 0) ? 4 : int'(l);
      for (int i = 0; i < 4; i++) blk_in[i] = rnd128();
      model(k, v, m, n);
      run(k, v, m, l, n, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfb_ctrl.md
CFB_CTRL -- requirements
Module: cfb_ctrl

Interface
REQ-001 Parameter: LEN_W, 16, width of block-count input; LEN=0 means 2^LEN_W blocks.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; loads key, iv, mode, len; accepted only in IDLE.
REQ-005 mode  in  1  0 = encrypt, 1 = decrypt.
REQ-006 key  in  128  AES-128 key, sampled at start.
REQ-007 iv  in  128  initial feedback register value, sampled at start.
REQ-008 len  in  LEN_W  number of 128-bit blocks in the message.
REQ-009 in_valid / in_ready  in / out  1 / 1  input block handshake.
REQ-010 in_data  in  128  plaintext (enc) or ciphertext (dec) block.
REQ-011 out_valid / out_ready  out / in  1 / 1  output block handshake.
REQ-012 out_data  out  128  ciphertext (enc) or plaintext (dec) block.
REQ-013 core_start  out  1  one-cycle pulse launching the AES-128 forward cipher.
REQ-014 core_din / core_key  out / out  128 / 128  cipher input (feedback reg) / latched key.
REQ-015 core_done / core_dout  in / in  1 / 128  cipher completion pulse / keystream block.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the last output block is accepted.

Function
REQ-018 States SHALL be IDLE, LAUNCH, WAIT_CORE, WAIT_IN, OUT.
REQ-019 IDLE: start=1 -> latch key, iv into fb_reg, mode, len into remaining counter; go LAUNCH.
REQ-020 LAUNCH: core_start=1 for exactly this cycle, core_din=fb_reg; go WAIT_CORE next cycle.
REQ-021 WAIT_CORE: on core_done=1 latch core_dout into ks_reg; go WAIT_IN; core_done in any other state SHALL be ignored.
REQ-022 Keystream for block n SHALL be generated before block n's input is accepted; in_ready=1 only in WAIT_IN.
REQ-023 WAIT_IN: on in_valid&&in_ready -> out_reg = in_data XOR ks_reg; fb_reg = out_reg (mode 0) or in_data (mode 1); go OUT.
REQ-024 OUT: out_valid=1, out_data=out_reg held stable until out_ready=1.
REQ-025 OUT with out_ready=1: decrement remaining; if remaining was 1, pulse done and go IDLE; else go LAUNCH.
REQ-026 Counter: LEN_W+1 bits; len=0 loads 2^LEN_W; wrap past zero SHALL not occur.
REQ-027 start outside IDLE SHALL be ignored; key/iv/mode/len changes after start SHALL have no effect.
REQ-028 Per block latency: LAUNCH 1 cycle + core latency + 1 cycle to WAIT_IN; output valid the cycle after input handshake.
REQ-029 in_valid while not in WAIT_IN SHALL not be consumed; out_ready while not in OUT SHALL have no effect.
REQ-030 done and out_valid SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL force IDLE from any state, including mid-block and while core busy, next edge.
REQ-032 Reset values: in_ready=0, out_valid=0, out_data=0, core_start=0, core_din=0, core_key=0, busy=0, done=0, all internal registers 0.
REQ-033 rst dominates start in the same cycle; a core_done arriving after reset SHALL be ignored.

Verification (behavioural AES core, 10-cycle latency)
REQ-034 Enc, key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, len=2, in 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 -> out 3b3fd92eb72dad20333449f8e83cfb4a, c8a64537a0b3a93fcde3cdad9f1ce58b, one done pulse.
REQ-035 Dec, same key/iv, len=2, in the two ciphertexts above -> out the two plaintexts above; second core_din = 3b3fd92eb72dad20333449f8e83cfb4a.
REQ-036 Back-pressure: out_ready=0 for 5 cycles in OUT -> out_data stable, no core_start, in_ready=0 throughout.
REQ-037 Reset mid-run: rst asserted in WAIT_CORE of block 1 -> IDLE, busy=0; later core_done ignored; fresh start with REQ-034 stimulus gives REQ-034 results.
REQ-038 Boundary: LEN_W=2, len=0 -> exactly 4 blocks processed, done after 4th accept; start pulsed while busy -> ignored.
